fetch_unit: RTL

- Instruction fetch stage directly upstream of the decoder.
- Fetches 16-bit words over a req/ack memory port and assembles one- or two-word instructions.
- A word with bit 15 set carries a trailing immediate word. MOVB-class opcodes are single-word.
- Presents instruction, immediate word and PC to the decoder with a valid/ready handshake, and accepts PC redirects (jump/call/return) from execute.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the two handshake buses of the instruction fetch stage.
//   Memory read port (req/ack):
//     mem_req, mem_addr       fetch unit -> memory
//     mem_ack, mem_rdata      memory -> fetch unit
//   Decoder port (valid/ready):
//     instruction, imm_word, instr_pc, next_pc, instr_valid  fetch -> decoder
//     decode_ready                                           decoder -> fetch
//   master: the fetch unit side; slave: the memory/decoder side.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic [15:0] imm_word;
    logic [15:0] instr_pc;
    logic [15:0] next_pc;
    logic        instr_valid;
    logic        decode_ready;

    modport master (
        output mem_req, mem_addr, instruction, imm_word, instr_pc, next_pc, instr_valid,
        input  mem_ack, mem_rdata, decode_ready
    );

    modport slave (
        input  mem_req, mem_addr, instruction, imm_word, instr_pc, next_pc, instr_valid,
        output mem_ack, mem_rdata, decode_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Reads 16-bit words over a
//   req/ack memory port and assembles one-word instructions, or two-word
//   instructions when bit 15 of the first word is set (immediate follows).
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     io_fetch   fetch_unit_if.master: memory port and decoder handshake
//     i_pc_load  PC redirect request from execute (highest priority)
//     i_pc_new   redirect target
//     i_halt     stop issuing new fetches (sampled in IDLE and at transfer)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_unit_if.master   io_fetch,
    input  logic           i_pc_load,
    input  logic [15:0]    i_pc_new,
    input  logic           i_halt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F1    = 3'd1,
        S_F2    = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state,       w_state_next;
    logic [15:0] r_pc,          w_pc_next;
    logic        r_mem_req,     w_mem_req_next;
    logic [15:0] r_mem_addr,    w_mem_addr_next;
    logic [15:0] r_instruction, w_instruction_next;
    logic [15:0] r_imm_word,    w_imm_word_next;
    logic [15:0] r_instr_pc,    w_instr_pc_next;
    logic [15:0] r_next_pc,     w_next_pc_next;
    logic        r_instr_valid, w_instr_valid_next;
    logic [15:0] w_pc_inc;

    // 16-bit modulo increment: 0xFFFE + 2 wraps to 0x0000
    assign w_pc_inc = r_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_instruction <= 16'h0000;
            r_imm_word    <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_next_pc     <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_mem_req     <= w_mem_req_next;
            r_mem_addr    <= w_mem_addr_next;
            r_instruction <= w_instruction_next;
            r_imm_word    <= w_imm_word_next;
            r_instr_pc    <= w_instr_pc_next;
            r_next_pc     <= w_next_pc_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_mem_req_next     = r_mem_req;
        w_mem_addr_next    = r_mem_addr;
        w_instruction_next = r_instruction;
        w_imm_word_next    = r_imm_word;
        w_instr_pc_next    = r_instr_pc;
        w_next_pc_next     = r_next_pc;
        w_instr_valid_next = r_instr_valid;

        if (i_pc_load) begin
            w_pc_next          = i_pc_new;
            w_instr_valid_next = 1'b0;
            // An outstanding request cannot be withdrawn: keep req/addr
            // and swallow its data in DRAIN. Otherwise restart cleanly in
            // F1 with req low; F1 raises it at the new pc next cycle.
            if ((r_state == S_F1 || r_state == S_F2 || r_state == S_DRAIN) &&
                r_mem_req && !io_fetch.mem_ack) begin
                w_state_next = S_DRAIN;
            end else begin
                w_state_next   = S_F1;
                w_mem_req_next = 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!i_halt) begin
                        w_state_next    = S_F1;
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = r_pc;
                    end
                end
                S_F1: begin
                    if (!r_mem_req) begin
                        // re-request cycle after a transfer, drain or redirect
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = r_pc;
                    end else if (io_fetch.mem_ack) begin
                        w_instruction_next = io_fetch.mem_rdata;
                        w_instr_pc_next    = r_pc;
                        w_pc_next          = w_pc_inc;
                        if (io_fetch.mem_rdata[15]) begin
                            // immediate word follows; keep req high
                            w_state_next    = S_F2;
                            w_mem_addr_next = w_pc_inc;
                        end else begin
                            w_state_next       = S_OUT;
                            w_imm_word_next    = 16'h0000;
                            w_next_pc_next     = w_pc_inc;
                            w_mem_req_next     = 1'b0;
                            w_instr_valid_next = 1'b1;
                        end
                    end
                end
                S_F2: begin
                    if (io_fetch.mem_ack) begin
                        w_state_next       = S_OUT;
                        w_imm_word_next    = io_fetch.mem_rdata;
                        w_pc_next          = w_pc_inc;
                        w_next_pc_next     = w_pc_inc;
                        w_mem_req_next     = 1'b0;
                        w_instr_valid_next = 1'b1;
                    end
                end
                S_OUT: begin
                    if (r_instr_valid && io_fetch.decode_ready) begin
                        w_instr_valid_next = 1'b0;
                        w_state_next       = i_halt ? S_IDLE : S_F1;
                    end
                end
                S_DRAIN: begin
                    if (io_fetch.mem_ack) begin
                        w_state_next   = S_F1;
                        w_mem_req_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next   = S_IDLE;
                    w_mem_req_next = 1'b0;
                end
            endcase
        end
    end

    assign io_fetch.mem_req     = r_mem_req;
    assign io_fetch.mem_addr    = r_mem_addr;
    assign io_fetch.instruction = r_instruction;
    assign io_fetch.imm_word    = r_imm_word;
    assign io_fetch.instr_pc    = r_instr_pc;
    assign io_fetch.next_pc     = r_next_pc;
    assign io_fetch.instr_valid = r_instr_valid;

endmodule
